// File: rtl/junction_phase_controller.sv
// ----------------------------------------------------------------------------
// junction_phase_controller
//
// Demand-actuated two-road junction controller. Both light heads follow the
// UK sequence (red, red+amber, green, amber) and the junction is handed
// between road A and road B on demand. Vehicle requests are latched into
// pending flags. A green is held between minimum and maximum bounds while the
// other road waits, and rests indefinitely when nobody else is waiting. All
// phase timing advances only on the external slow strobe `tick`.
//
// Optional feature macro: ALL_RED_EN
//   defined   : an all-red clearance (AR_AB / AR_BA, ALLRED_TICKS long) is
//               inserted after each amber.
//   undefined : amber leads straight to the other road's red+amber.
//
// Ports
//   clk      in   1  clock
//   rst      in   1  asynchronous, active-high reset
//   tick     in   1  timing strobe, one clk wide; timers advance only on it
//   req_a    in   1  vehicle present on road A (level)
//   req_b    in   1  vehicle present on road B (level)
//   lightsA  out  3  road A head {green,amber,red}
//   lightsB  out  3  road B head {green,amber,red}
//   phase    out  3  current FSM state (debug)
// ----------------------------------------------------------------------------
module junction_phase_controller #(
    parameter int GREEN_MIN    = 4,
    parameter int GREEN_MAX    = 10,
    parameter int AMBER_TICKS  = 3,
    parameter int RA_TICKS     = 2,
    parameter int ALLRED_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       req_a,
    input  logic       req_b,
    output logic [2:0] lightsA,
    output logic [2:0] lightsB,
    output logic [2:0] phase
);

    localparam int TW = $clog2(GREEN_MAX + 1);

    // Timer values at which each phase ends (timer counts completed ticks).
    localparam logic [TW-1:0] GMIN_LAST = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX_LAST = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] AMB_LAST  = TW'(AMBER_TICKS - 1);
    localparam logic [TW-1:0] RA_LAST   = TW'(RA_TICKS - 1);
    localparam logic [TW-1:0] AR_LAST   = TW'(ALLRED_TICKS - 1);
    localparam logic [TW-1:0] TMR_ZERO  = TW'(0);
    localparam logic [TW-1:0] TMR_ONE   = TW'(1);

    // Light codes {green,amber,red}.
    localparam logic [2:0] L_GRN = 3'b100;
    localparam logic [2:0] L_AMB = 3'b010;
    localparam logic [2:0] L_RED = 3'b001;
    localparam logic [2:0] L_RA  = 3'b011;

    typedef enum logic [2:0] {
        A_GRN = 3'd0,
        A_AMB = 3'd1,
        AR_AB = 3'd2,
        B_RA  = 3'd3,
        B_GRN = 3'd4,
        B_AMB = 3'd5,
        AR_BA = 3'd6,
        A_RA  = 3'd7
    } state_e;

`ifdef ALL_RED_EN
    localparam state_e AFTER_A_AMB = AR_AB;
    localparam state_e AFTER_B_AMB = AR_BA;
`else
    localparam state_e AFTER_A_AMB = B_RA;
    localparam state_e AFTER_B_AMB = A_RA;
`endif

    // Head decode {lightsA, lightsB}; the road not named in a state is red.
    function automatic logic [5:0] head_decode(input state_e s);
        logic [5:0] heads;
        case (s)
            A_GRN:   heads = {L_GRN, L_RED};
            A_AMB:   heads = {L_AMB, L_RED};
            AR_AB:   heads = {L_RED, L_RED};
            B_RA:    heads = {L_RED, L_RA};
            B_GRN:   heads = {L_RED, L_GRN};
            B_AMB:   heads = {L_RED, L_AMB};
            AR_BA:   heads = {L_RED, L_RED};
            A_RA:    heads = {L_RA,  L_RED};
            default: heads = {L_RED, L_RED};
        endcase
        return heads;
    endfunction

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            pend_a_q, pend_a_d;
    logic            pend_b_q, pend_b_d;
    logic [2:0]      lights_a_q, lights_b_q;
    logic [5:0]      heads_d;
    logic            a_green_done_s;
    logic            b_green_done_s;

    // A green yields only when the other road waits: at the max bound, or
    // past the min bound once its own traffic has stopped flowing.
    assign a_green_done_s = pend_b_q &&
                            ((timer_q == GMAX_LAST) || ((timer_q >= GMIN_LAST) && !req_a));
    assign b_green_done_s = pend_a_q &&
                            ((timer_q == GMAX_LAST) || ((timer_q >= GMIN_LAST) && !req_b));

    // Next-state logic: all transitions happen only on a tick.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                A_GRN:   state_d = a_green_done_s       ? A_AMB       : A_GRN;
                A_AMB:   state_d = (timer_q == AMB_LAST) ? AFTER_A_AMB : A_AMB;
                AR_AB:   state_d = (timer_q == AR_LAST)  ? B_RA        : AR_AB;
                B_RA:    state_d = (timer_q == RA_LAST)  ? B_GRN       : B_RA;
                B_GRN:   state_d = b_green_done_s       ? B_AMB       : B_GRN;
                B_AMB:   state_d = (timer_q == AMB_LAST) ? AFTER_B_AMB : B_AMB;
                AR_BA:   state_d = (timer_q == AR_LAST)  ? A_RA        : AR_BA;
                A_RA:    state_d = (timer_q == RA_LAST)  ? A_GRN       : A_RA;
                default: state_d = A_GRN;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Phase timer: restarts on every state change, saturates so a resting
    // green can still be measured against the max bound.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = TMR_ZERO;
        end else if (tick && (timer_q != GMAX_LAST)) begin
            timer_d = timer_q + TMR_ONE;
        end else begin
            timer_d = timer_q;
        end
    end

    // Request latches: entering a road's green clears its flag and beats a
    // same-cycle request; a request during its own green means "still flowing".
    always_comb begin
        pend_a_d = pend_a_q;
        pend_b_d = pend_b_q;
        if ((state_d == A_GRN) && (state_q != A_GRN)) begin
            pend_a_d = 1'b0;
        end else if (req_a && (state_q != A_GRN)) begin
            pend_a_d = 1'b1;
        end else begin
            pend_a_d = pend_a_q;
        end
        if ((state_d == B_GRN) && (state_q != B_GRN)) begin
            pend_b_d = 1'b0;
        end else if (req_b && (state_q != B_GRN)) begin
            pend_b_d = 1'b1;
        end else begin
            pend_b_d = pend_b_q;
        end
    end

    // Heads are decoded from the next state and registered, so they change
    // on the same edge as the state and never see the request inputs directly.
    always_comb begin
        heads_d = head_decode(state_d);
    end

    // State, timer, pending flags and registered light heads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= A_GRN;
            timer_q    <= TMR_ZERO;
            pend_a_q   <= 1'b0;
            pend_b_q   <= 1'b0;
            lights_a_q <= L_GRN;
            lights_b_q <= L_RED;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pend_a_q   <= pend_a_d;
            pend_b_q   <= pend_b_d;
            lights_a_q <= heads_d[5:3];
            lights_b_q <= heads_d[2:0];
        end
    end

    assign lightsA = lights_a_q;
    assign lightsB = lights_b_q;
    assign phase   = state_q;

endmodule
